hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline sequencer for the 8-bit 5-stage core. Decodes ID/EX hazards and drives the
//   stall/flush/bubble controls of PC, IF/ID and ID/EX registers. Owns the interrupt
//   entry sequence: drain in-flight instructions, then redirect PC to the vector.
//   Sits beside the ID stage; inputs come from decode and the ID/EX register outputs.
// PARAMETERS
//   LOAD_STALL    1  cycles of ID/EX bubble per load-use hazard (1..3)
//   DRAIN_CYCLES  3  cycles fetch is frozen before interrupt vectoring (1..7)
//   CNT_W         16 width of perf counters (HAZ_PERF_CNT_EN only)
// PORTS
//   clk             in   1      rising-edge clock
//   rst             in   1      async reset, active low
//   id_ra, id_rb    in   2      source register addresses of instruction in ID
//   id_uses_ra/rb   in   1      ID instruction actually reads ra / rb
//   ex_mem_read     in   1      MemRead_out of ID/EX register
//   ex_reg_write    in   1      RegWrite_out of ID/EX register
//   ex_rd           in   2      destination reg of instruction in EX (resolved from RegDistidx)
//   ex_branch_taken in   1      branch/jump in EX resolved taken this cycle
//   irq             in   1      level interrupt request, held until irq_ack
//   pc_write_en     out  1      PC register load enable
//   pc_sel_vector   out  1      PC mux selects interrupt vector
//   if_id_write_en  out  1      IF/ID load enable (0 = hold)
//   if_id_flush     out  1      IF/ID clears to NOP
//   id_ex_flush     out  1      ID/EX flush input
//   id_ex_bubble    out  1      ID/EX inject_bubble input
//   irq_ack         out  1      one-cycle interrupt acknowledge
//   stall_cnt       out  CNT_W  load-use stall cycles (HAZ_PERF_CNT_EN only)
//   flush_cnt       out  CNT_W  branch flush events (HAZ_PERF_CNT_EN only)
// BEHAVIOUR
//   Outputs combinational from state + inputs; state, counters registered.
//   rst low: state=RUN, counters=0; all outputs 0 while rst low. Async reset aborts any sequence.
//   load_use = ex_mem_read & ex_reg_write & ((id_uses_ra & id_ra==ex_rd) | (id_uses_rb & id_rb==ex_rd)).
//   RUN (default outputs: pc_write_en=1, if_id_write_en=1, others 0). Priority, same cycle:
//     1 ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_write_en=1; stay RUN.
//     2 load_use: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1; cnt=LOAD_STALL-1;
//       -> STALL if LOAD_STALL>1, else stay RUN.
//     3 irq: pc_write_en=0, if_id_flush=1; cnt=DRAIN_CYCLES-1; -> DRAIN.
//   STALL: same outputs as RUN-2; cnt decrements; cnt==0 -> RUN next cycle.
//     ex_branch_taken in STALL aborts: RUN-1 outputs, -> RUN.
//   DRAIN: pc_write_en=0, if_id_write_en=1, if_id_flush=1; cnt decrements; cnt==0 -> VECTOR.
//     ex_branch_taken in DRAIN: pc_write_en=1 (PC takes target so return PC is correct),
//     id_ex_flush=1, cnt reloads DRAIN_CYCLES-1.
//   VECTOR (1 cycle): irq_ack=1, pc_sel_vector=1, pc_write_en=1, if_id_flush=1; -> RUN.
//   irq ignored outside RUN; never acked twice per assertion (irq must drop after ack).
//   load_use not evaluated in DRAIN/VECTOR (ID holds NOP).
//   Total interrupt latency from irq sample in RUN to irq_ack: DRAIN_CYCLES+1 cycles.
// CONFIGURATION
//   HAZ_PERF_CNT_EN defined: stall_cnt +1 each cycle id_ex_bubble=1; flush_cnt +1 each
//     cycle ex_branch_taken causes id_ex_flush; both saturate at all-ones; reset to 0.
//   Undefined: stall_cnt/flush_cnt ports absent, no counter flops.
// TESTING
//   1 reset mid-DRAIN (rst low 1 cycle) -> all outputs 0 during reset, state RUN after.
//   2 ex_mem_read=1,ex_reg_write=1,ex_rd=2,id_ra=2,id_uses_ra=1, LOAD_STALL=1
//     -> exactly 1 cycle pc_write_en=0, id_ex_bubble=1; id_uses_ra=0 -> no stall.
//   3 LOAD_STALL=3 + ex_branch_taken in 2nd stall cycle -> both flushes=1, RUN next, total 2 bubble cycles.
//   4 irq=1 in RUN, DRAIN_CYCLES=3 -> 3 cycles pc_write_en=0, irq_ack=1 on 4th with pc_sel_vector=1.
//   5 load_use and ex_branch_taken same cycle -> flush wins, id_ex_bubble=0.
//   6 HAZ_PERF_CNT_EN: 5 load-use stalls + 2 taken branches -> stall_cnt=5, flush_cnt=2; saturate check CNT_W=2.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/interrupt sequencer for the 8-bit 5-stage core: load-use stalls, branch flushes, IRQ drain+vector.
// Optional perf counters (stall_cnt/flush_cnt) are built only when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL   = 1,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] id_ra,
    input  logic [1:0] id_rb,
    input  logic       id_uses_ra,
    input  logic       id_uses_rb,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [1:0] ex_rd,
    input  logic       ex_branch_taken,
    input  logic       irq,
    output logic       pc_write_en,
    output logic       pc_sel_vector,
    output logic       if_id_write_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       id_ex_bubble,
    output logic       irq_ack
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN, STALL, DRAIN, VECTOR} state_t;

    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);
    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

    if (LOAD_STALL < 1 || LOAD_STALL > 3 || DRAIN_CYCLES < 1 || DRAIN_CYCLES > 7 || CNT_W < 1)
    begin : g_param_range
        $error("hazard_ctrl: parameter out of range");
    end

    state_t     state;
    logic [2:0] cnt;
    logic       irq_block;
    logic       load_use;
    logic       irq_take;

    assign load_use = ex_mem_read & ex_reg_write &
                      ((id_uses_ra & (id_ra == ex_rd)) | (id_uses_rb & (id_rb == ex_rd)));
    // irq_block holds off a second entry until the level request has been seen low after an ack
    assign irq_take = irq & ~irq_block;

    always_comb begin
        pc_write_en    = 1'b0;
        pc_sel_vector  = 1'b0;
        if_id_write_en = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        irq_ack        = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    pc_write_en    = 1'b1;
                    if_id_write_en = 1'b1;
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_bubble   = 1'b1;
                    end else if (irq_take) begin
                        pc_write_en = 1'b0;
                        if_id_flush = 1'b1;
                    end
                end
                STALL: begin
                    if (ex_branch_taken) begin
                        pc_write_en    = 1'b1;
                        if_id_write_en = 1'b1;
                        if_id_flush    = 1'b1;
                        id_ex_flush    = 1'b1;
                    end else begin
                        id_ex_bubble = 1'b1;
                    end
                end
                DRAIN: begin
                    if_id_write_en = 1'b1;
                    if_id_flush    = 1'b1;
                    if (ex_branch_taken) begin
                        pc_write_en = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                VECTOR: begin
                    irq_ack       = 1'b1;
                    pc_sel_vector = 1'b1;
                    pc_write_en   = 1'b1;
                    if_id_flush   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            cnt       <= '0;
            irq_block <= 1'b0;
        end else begin
            irq_block <= irq_ack | (irq & irq_block);
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        state <= RUN;
                    end else if (load_use) begin
                        cnt <= STALL_INIT;
                        if (LOAD_STALL > 1) state <= STALL;
                    end else if (irq_take) begin
                        // the RUN cycle that samples irq is itself the first frozen cycle
                        cnt   <= DRAIN_INIT;
                        state <= (DRAIN_CYCLES > 1) ? DRAIN : VECTOR;
                    end
                end
                STALL: begin
                    if (ex_branch_taken) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 3'd1;
                        if (cnt <= 3'd1) state <= RUN;
                    end
                end
                DRAIN: begin
                    if (ex_branch_taken) begin
                        cnt <= DRAIN_INIT;
                    end else begin
                        cnt <= cnt - 3'd1;
                        if (cnt <= 3'd1) state <= VECTOR;
                    end
                end
                VECTOR: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (id_ex_bubble && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (id_ex_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a remaining-cycles reference model.
// Two instances (LOAD_STALL=1 and 3); perf-counter checks compile in only with HAZ_PERF_CNT_EN.
module tb_hazard_ctrl;

    // output vector bit order: {pc_write_en, pc_sel_vector, if_id_write_en, if_id_flush, id_ex_flush, id_ex_bubble, irq_ack}
    localparam logic [6:0] O_RUN = 7'b1010000;
    localparam logic [6:0] O_BR  = 7'b1011100;
    localparam logic [6:0] O_STL = 7'b0000010;
    localparam logic [6:0] O_IRQ = 7'b0011000;
    localparam logic [6:0] O_DRN = 7'b0011000;
    localparam logic [6:0] O_VEC = 7'b1101001;
    localparam int DC = 3;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] id_ra, id_rb, ex_rd;
    logic id_uses_ra, id_uses_rb, ex_mem_read, ex_reg_write, ex_branch_taken, irq;
    logic a_pcw, a_sel, a_ifw, a_iff, a_ixf, a_bub, a_ack;
    logic b_pcw, b_sel, b_ifw, b_iff, b_ixf, b_bub, b_ack;
    logic [6:0] a_out, b_out;
    int n_vec = 0;
    int n_bad = 0;

    int m_stall [2];
    int m_drain [2];
    bit m_vec [2];
    bit m_blk [2];
    int ls_of [2] = '{1, 3};

    always #5 clk = ~clk;

    assign a_out = {a_pcw, a_sel, a_ifw, a_iff, a_ixf, a_bub, a_ack};
    assign b_out = {b_pcw, b_sel, b_ifw, b_iff, b_ixf, b_bub, b_ack};

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
    logic [1:0]  c_scnt, c_fcnt;
    logic c_pcw, c_sel, c_ifw, c_iff, c_ixf, c_bub, c_ack;
`endif

    hazard_ctrl #(.LOAD_STALL(1), .DRAIN_CYCLES(DC)) dut_a (
        .clk(clk), .rst(rst), .id_ra(id_ra), .id_rb(id_rb), .id_uses_ra(id_uses_ra),
        .id_uses_rb(id_uses_rb), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .irq(irq),
        .pc_write_en(a_pcw), .pc_sel_vector(a_sel), .if_id_write_en(a_ifw), .if_id_flush(a_iff),
        .id_ex_flush(a_ixf), .id_ex_bubble(a_bub), .irq_ack(a_ack)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
`endif
    );

    hazard_ctrl #(.LOAD_STALL(3), .DRAIN_CYCLES(DC)) dut_b (
        .clk(clk), .rst(rst), .id_ra(id_ra), .id_rb(id_rb), .id_uses_ra(id_uses_ra),
        .id_uses_rb(id_uses_rb), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .irq(irq),
        .pc_write_en(b_pcw), .pc_sel_vector(b_sel), .if_id_write_en(b_ifw), .if_id_flush(b_iff),
        .id_ex_flush(b_ixf), .id_ex_bubble(b_bub), .irq_ack(b_ack)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
`endif
    );

`ifdef HAZ_PERF_CNT_EN
    hazard_ctrl #(.LOAD_STALL(1), .DRAIN_CYCLES(DC), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .id_ra(id_ra), .id_rb(id_rb), .id_uses_ra(id_uses_ra),
        .id_uses_rb(id_uses_rb), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .irq(irq),
        .pc_write_en(c_pcw), .pc_sel_vector(c_sel), .if_id_write_en(c_ifw), .if_id_flush(c_iff),
        .id_ex_flush(c_ixf), .id_ex_bubble(c_bub), .irq_ack(c_ack),
        .stall_cnt(c_scnt), .flush_cnt(c_fcnt)
    );
`endif

    task automatic clear_inputs();
        id_ra = 2'd0; id_rb = 2'd0; ex_rd = 2'd0;
        id_uses_ra = 1'b0; id_uses_rb = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0;
        ex_branch_taken = 1'b0; irq = 1'b0;
    endtask

    task automatic set_hazard();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 2'd2;
        id_ra = 2'd2; id_uses_ra = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            m_stall[k] = 0; m_drain[k] = 0; m_vec[k] = 1'b0; m_blk[k] = 1'b0;
        end
        @(negedge clk);
        next_cycle();
        rst = 1'b1;
    endtask

    // Reference: tracks how many frozen cycles remain rather than a state machine.
    task automatic model_step(input int k, output logic [6:0] e);
        bit lu;
        bit ack;
        lu = ex_mem_read && ex_reg_write &&
             ((id_uses_ra && id_ra == ex_rd) || (id_uses_rb && id_rb == ex_rd));
        ack = 1'b0;
        if (m_vec[k]) begin
            e = O_VEC; m_vec[k] = 1'b0; ack = 1'b1;
        end else if (m_drain[k] > 0) begin
            if (ex_branch_taken) begin
                e = O_BR; m_drain[k] = DC - 1;
            end else begin
                e = O_DRN; m_drain[k]--;
            end
            if (m_drain[k] == 0) m_vec[k] = 1'b1;
        end else if (m_stall[k] > 0) begin
            if (ex_branch_taken) begin
                e = O_BR; m_stall[k] = 0;
            end else begin
                e = O_STL; m_stall[k]--;
            end
        end else if (ex_branch_taken) begin
            e = O_BR;
        end else if (lu) begin
            e = O_STL; m_stall[k] = ls_of[k] - 1;
        end else if (irq && !m_blk[k]) begin
            e = O_IRQ; m_drain[k] = DC - 1;
            if (m_drain[k] == 0) m_vec[k] = 1'b1;
        end else begin
            e = O_RUN;
        end
        m_blk[k] = ack || (irq && m_blk[k]);
    endtask

    task automatic test_reset();
        do_reset();
        irq = 1'b1;
        @(negedge clk);
        n_vec++;
        if (a_out !== O_IRQ) begin n_bad++; $display("FAIL rst_irq_entry got=%b exp=%b", a_out, O_IRQ); end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (a_out !== O_DRN) begin n_bad++; $display("FAIL rst_drain got=%b exp=%b", a_out, O_DRN); end
        next_cycle();
        rst = 1'b0;
        irq = 1'b0;
        @(negedge clk);
        n_vec++;
        if (a_out !== 7'b0 || b_out !== 7'b0) begin
            n_bad++; $display("FAIL rst_outputs_zero got_a=%b got_b=%b exp=0000000", a_out, b_out);
        end
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (a_out !== O_RUN || b_out !== O_RUN) begin
                n_bad++; $display("FAIL rst_back_to_run cyc=%0d got_a=%b got_b=%b exp=%b", i, a_out, b_out, O_RUN);
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_hazard();
        @(negedge clk);
        n_vec++;
        if (a_out !== O_STL) begin n_bad++; $display("FAIL lu_ra_stall got=%b exp=%b", a_out, O_STL); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_vec++;
        if (a_out !== O_RUN) begin n_bad++; $display("FAIL lu_single_cycle got=%b exp=%b", a_out, O_RUN); end
        next_cycle();
        set_hazard();
        id_uses_ra = 1'b0;
        @(negedge clk);
        n_vec++;
        if (a_out !== O_RUN) begin n_bad++; $display("FAIL lu_unused_ra got=%b exp=%b", a_out, O_RUN); end
        next_cycle();
        id_uses_rb = 1'b1; id_rb = 2'd2;
        @(negedge clk);
        n_vec++;
        if (a_out !== O_STL) begin n_bad++; $display("FAIL lu_rb_stall got=%b exp=%b", a_out, O_STL); end
        next_cycle();
        ex_reg_write = 1'b0;
        @(negedge clk);
        n_vec++;
        if (a_out !== O_RUN) begin n_bad++; $display("FAIL lu_no_regwrite got=%b exp=%b", a_out, O_RUN); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_stall_abort();
        int bubbles;
        logic [6:0] exp_seq [4];
        exp_seq = '{O_STL, O_STL, O_BR, O_RUN};
        bubbles = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            if (i == 0) set_hazard();
            if (i == 2) ex_branch_taken = 1'b1;
            @(negedge clk);
            n_vec++;
            if (b_out !== exp_seq[i]) begin
                n_bad++; $display("FAIL stall_abort cyc=%0d got=%b exp=%b", i, b_out, exp_seq[i]);
            end
            if (b_bub === 1'b1) bubbles++;
            next_cycle();
        end
        n_vec++;
        if (bubbles != 2) begin n_bad++; $display("FAIL stall_abort_bubbles got=%0d exp=2", bubbles); end
        clear_inputs();
    endtask

    task automatic test_irq();
        int frozen;
        logic [6:0] exp_seq [8];
        logic [6:0] exp_br [6];
        frozen = 0;
        exp_seq = '{O_IRQ, O_DRN, O_DRN, O_VEC, O_RUN, O_RUN, O_IRQ, O_DRN};
        do_reset();
        irq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) irq = 1'b0;
            if (i == 6) irq = 1'b1;
            @(negedge clk);
            n_vec++;
            if (a_out !== exp_seq[i]) begin
                n_bad++; $display("FAIL irq_seq cyc=%0d got=%b exp=%b", i, a_out, exp_seq[i]);
            end
            if (i < 4 && a_pcw === 1'b0) frozen++;
            next_cycle();
        end
        n_vec++;
        if (frozen != 3) begin n_bad++; $display("FAIL irq_frozen_cycles got=%0d exp=3", frozen); end
        exp_br = '{O_IRQ, O_BR, O_DRN, O_DRN, O_VEC, O_RUN};
        do_reset();
        irq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ex_branch_taken = (i == 1);
            if (i == 5) irq = 1'b0;
            @(negedge clk);
            n_vec++;
            if (a_out !== exp_br[i]) begin
                n_bad++; $display("FAIL irq_drain_branch cyc=%0d got=%b exp=%b", i, a_out, exp_br[i]);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        set_hazard();
        ex_branch_taken = 1'b1;
        irq = 1'b1;
        @(negedge clk);
        n_vec++;
        if (a_out !== O_BR || b_out !== O_BR) begin
            n_bad++; $display("FAIL prio_branch_wins got_a=%b got_b=%b exp=%b", a_out, b_out, O_BR);
        end
        next_cycle();
        ex_branch_taken = 1'b0;
        @(negedge clk);
        n_vec++;
        if (a_out !== O_STL) begin n_bad++; $display("FAIL prio_lu_over_irq got=%b exp=%b", a_out, O_STL); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [6:0] ea, eb;
        bit drop;
        drop = 1'b0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            id_ra = 2'($urandom_range(0, 3));
            id_rb = 2'($urandom_range(0, 3));
            ex_rd = 2'($urandom_range(0, 3));
            id_uses_ra = ($urandom_range(0, 1) == 1);
            id_uses_rb = ($urandom_range(0, 1) == 1);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_reg_write = ($urandom_range(0, 2) != 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            if (drop) irq = 1'b0;
            else if (!irq && $urandom_range(0, 15) == 0) irq = 1'b1;
            @(negedge clk);
            model_step(0, ea);
            model_step(1, eb);
            drop = ea[0] || eb[0];
            n_vec++;
            if (a_out !== ea) begin n_bad++; $display("FAIL rand_a cyc=%0d got=%b exp=%b", i, a_out, ea); end
            n_vec++;
            if (b_out !== eb) begin n_bad++; $display("FAIL rand_b cyc=%0d got=%b exp=%b", i, b_out, eb); end
            next_cycle();
        end
        clear_inputs();
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf_counters();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_hazard();
            next_cycle();
            clear_inputs();
            next_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            ex_branch_taken = 1'b1;
            next_cycle();
            clear_inputs();
            next_cycle();
        end
        @(negedge clk);
        n_vec++;
        if (a_scnt !== 16'd5) begin n_bad++; $display("FAIL perf_stall_cnt got=%0d exp=5", a_scnt); end
        n_vec++;
        if (a_fcnt !== 16'd2) begin n_bad++; $display("FAIL perf_flush_cnt got=%0d exp=2", a_fcnt); end
        n_vec++;
        if (c_scnt !== 2'd3) begin n_bad++; $display("FAIL perf_stall_sat got=%0d exp=3", c_scnt); end
        n_vec++;
        if (c_fcnt !== 2'd2) begin n_bad++; $display("FAIL perf_flush_w2 got=%0d exp=2", c_fcnt); end
    endtask
`endif

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_stall_abort();
        test_irq();
        test_priority();
`ifdef HAZ_PERF_CNT_EN
        test_perf_counters();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
